// File: rtl/pcie_msi_receiver.sv
`default_nettype none
// ============================================================================
// Module      : pcie_msi_receiver
// Description : Receives inbound PCIe MSI memory writes aimed at a doorbell
//               address. It latches per-vector pending bits, counts writes
//               that merge into an already-pending vector, and presents the
//               lowest-index unmasked pending vector to the host through a
//               valid/ack handshake.
//               Optional feature macro: PCIE_MSI_RX_MASK_EN
//                 defined   -> per-vector mask register, written through
//                              cfg_mask_we / cfg_mask_wdata
//                 undefined -> every vector enabled; cfg_mask_* ignored
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_msi_receiver #(
    parameter logic [31:0] MSI_ADDR = 32'hFEE0_0000,
    parameter int          NUM_VEC  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [31:0]                wr_addr,
    input  logic [31:0]                wr_data,
    output logic                       irq_valid,
    output logic [$clog2(NUM_VEC)-1:0] irq_vector,
    input  logic                       irq_ack,
    output logic [NUM_VEC-1:0]         pending,
    output logic [15:0]                coalesce_cnt,
    output logic                       addr_miss,
    input  logic                       cfg_mask_we,
    input  logic [NUM_VEC-1:0]         cfg_mask_wdata
);

    localparam int          VEC_W   = $clog2(NUM_VEC);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_VEC-1:0] pending_q, pending_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               miss_q, miss_d;

    logic               w_accept;
    logic               w_hit;
    logic [VEC_W-1:0]   w_wr_vec;
    logic               w_clr;
    logic [NUM_VEC-1:0] w_mask;
    logic [NUM_VEC-1:0] w_eligible;
    logic               w_any;
    logic [VEC_W-1:0]   w_sel_vec;

    // Requests always complete in one cycle; only reset holds them off.
    assign wr_ready = rst_n;
    assign w_accept = wr_valid & wr_ready;
    assign w_hit    = w_accept & (wr_addr == MSI_ADDR);
    assign w_wr_vec = wr_data[VEC_W-1:0];
    assign w_clr    = (state_q == ST_PRESENT) & irq_ack;

`ifdef PCIE_MSI_RX_MASK_EN
    logic [NUM_VEC-1:0] mask_q;

    // Mask register; a new value takes effect at the next IDLE selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (cfg_mask_we) begin
            mask_q <= cfg_mask_wdata;
        end
    end

    assign w_mask = mask_q;

    logic w_unused_bits;
    assign w_unused_bits = ^wr_data[31:VEC_W];
`else
    assign w_mask = '0;

    logic w_unused_bits;
    assign w_unused_bits = ^{wr_data[31:VEC_W], cfg_mask_we, cfg_mask_wdata};
`endif

    assign w_eligible = pending_q & ~w_mask;
    assign w_any      = |w_eligible;

    // Priority encoder: lowest-index eligible vector wins.
    always_comb begin
        w_sel_vec = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel_vec = i[VEC_W-1:0];
            end
        end
    end

    // Pending bits, coalesce counter and address-miss pulse next state.
    // A set in the same cycle as the ack-clear of that vector wins.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        miss_d    = w_accept & ~w_hit;
        if (w_clr) begin
            pending_d[vec_q] = 1'b0;
        end
        if (w_hit) begin
            pending_d[w_wr_vec] = 1'b1;
            if (pending_q[w_wr_vec] && !(w_clr && (vec_q == w_wr_vec))
                && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Presentation FSM next state: select in IDLE, hold until ack in PRESENT.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    vec_d   = w_sel_vec;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (irq_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
        end
    end

    assign irq_valid    = (state_q == ST_PRESENT);
    assign irq_vector   = vec_q;
    assign pending      = pending_q;
    assign coalesce_cnt = cnt_q;
    assign addr_miss    = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_msi_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_msi_receiver
// Description : Directed self-checking bench for pcie_msi_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_msi_receiver;

    localparam logic [31:0] C_ADDR = 32'hFEE0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        irq_valid;
    logic [4:0]  irq_vector;
    logic        irq_ack;
    logic [31:0] pending;
    logic [15:0] coalesce_cnt;
    logic        addr_miss;
    logic        cfg_mask_we;
    logic [31:0] cfg_mask_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    pcie_msi_receiver #(
        .MSI_ADDR (C_ADDR),
        .NUM_VEC  (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .irq_valid      (irq_valid),
        .irq_vector     (irq_vector),
        .irq_ack        (irq_ack),
        .pending        (pending),
        .coalesce_cnt   (coalesce_cnt),
        .addr_miss      (addr_miss),
        .cfg_mask_we    (cfg_mask_we),
        .cfg_mask_wdata (cfg_mask_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        wr_valid       = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        irq_ack        = 1'b0;
        cfg_mask_we    = 1'b0;
        cfg_mask_wdata = '0;

        // Reset values
        #2;
        chk("rst_wr_ready",  {31'd0, wr_ready},     32'd0);
        chk("rst_irq_valid", {31'd0, irq_valid},    32'd0);
        chk("rst_irq_vec",   {27'd0, irq_vector},   32'd0);
        chk("rst_pending",   pending,               32'd0);
        chk("rst_cnt",       {16'd0, coalesce_cnt}, 32'd0);
        chk("rst_miss",      {31'd0, addr_miss},    32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("ready_out_of_rst", {31'd0, wr_ready}, 32'd1);

        // Single vector 5; upper data bits ignored
        wr(C_ADDR, 32'hABCD_0005);
        chk("v5_pending",   pending,              32'h0000_0020);
        chk("v5_not_yet",   {31'd0, irq_valid},   32'd0);
        tick();
        chk("v5_valid",     {31'd0, irq_valid},   32'd1);
        chk("v5_vector",    {27'd0, irq_vector},  32'd5);
        tick();
        chk("v5_hold",      {31'd0, irq_valid},   32'd1);
        ack();
        chk("v5_clr_pend",  pending,              32'd0);
        chk("v5_clr_valid", {31'd0, irq_valid},   32'd0);

        // Vectors 9 then 3 written while 12 is presented: 3 goes before 9
        wr(C_ADDR, 32'd12);
        tick();
        chk("v12_vector", {27'd0, irq_vector}, 32'd12);
        wr(C_ADDR, 32'd9);
        wr(C_ADDR, 32'd3);
        chk("v12_hold_vec", {27'd0, irq_vector}, 32'd12);
        chk("three_pend",   pending,             32'h0000_1208);
        ack();
        chk("after12_gap",  {31'd0, irq_valid},  32'd0);
        chk("after12_pend", pending,             32'h0000_0208);
        tick();
        chk("v3_first",     {27'd0, irq_vector}, 32'd3);
        chk("v3_valid",     {31'd0, irq_valid},  32'd1);
        ack();
        chk("gap_idle",     {31'd0, irq_valid},  32'd0);
        tick();
        chk("v9_valid",     {31'd0, irq_valid},  32'd1);
        chk("v9_vector",    {27'd0, irq_vector}, 32'd9);
        ack();
        chk("all_clear",    pending,             32'd0);
        chk("no_coalesce",  {16'd0, coalesce_cnt}, 32'd0);

        // Address miss
        wr(32'hFEE0_0004, 32'd5);
        chk("miss_pulse",   {31'd0, addr_miss}, 32'd1);
        chk("miss_pend",    pending,            32'd0);
        tick();
        chk("miss_one_cyc", {31'd0, addr_miss}, 32'd0);
        chk("miss_no_irq",  {31'd0, irq_valid}, 32'd0);

        // Mask behaviour
        cfg_mask_we    = 1'b1;
        cfg_mask_wdata = 32'h1;
        tick();
        cfg_mask_we    = 1'b0;
        wr(C_ADDR, 32'd0);
        chk("m_pend0", pending, 32'h1);
        tick();
        tick();
`ifdef PCIE_MSI_RX_MASK_EN
        chk("m_no_irq", {31'd0, irq_valid}, 32'd0);
        cfg_mask_we    = 1'b1;
        cfg_mask_wdata = 32'h0;
        tick();
        cfg_mask_we    = 1'b0;
        chk("m_still_idle", {31'd0, irq_valid}, 32'd0);
        tick();
        chk("m_present",  {31'd0, irq_valid},  32'd1);
        chk("m_vec0",     {27'd0, irq_vector}, 32'd0);
        cfg_mask_we    = 1'b1;
        cfg_mask_wdata = 32'h1;
        tick();
        cfg_mask_we    = 1'b0;
        chk("m_no_retract", {31'd0, irq_valid}, 32'd1);
        ack();
        cfg_mask_we    = 1'b1;
        cfg_mask_wdata = 32'h0;
        tick();
        cfg_mask_we    = 1'b0;
`else
        chk("m_ignored",  {31'd0, irq_valid},  32'd1);
        chk("m_vec0",     {27'd0, irq_vector}, 32'd0);
        ack();
`endif
        chk("m_cleared", pending, 32'd0);

        // Coalescing and saturation on vector 7
        wr(C_ADDR, 32'd7);
        wr(C_ADDR, 32'd7);
        wr(C_ADDR, 32'd7);
        chk("co_pend",   pending,               32'h80);
        chk("co_cnt2",   {16'd0, coalesce_cnt}, 32'd2);
        wr_valid = 1'b1;
        wr_addr  = C_ADDR;
        wr_data  = 32'd7;
        for (int i = 0; i < 65533; i++) begin
            tick();
        end
        chk("co_cnt_max", {16'd0, coalesce_cnt}, 32'h0000_FFFF);
        tick();
        tick();
        wr_valid = 1'b0;
        chk("co_cnt_sat", {16'd0, coalesce_cnt}, 32'h0000_FFFF);
        chk("co_vec7",    {27'd0, irq_vector},   32'd7);
        ack();
        chk("co_clear",   pending, 32'd0);

        // Reset mid-presentation
        wr(C_ADDR, 32'd4);
        tick();
        chk("r_v4_valid", {31'd0, irq_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r_valid_drop", {31'd0, irq_valid},    32'd0);
        chk("r_pend_drop",  pending,               32'd0);
        chk("r_cnt_drop",   {16'd0, coalesce_cnt}, 32'd0);
        chk("r_vec_drop",   {27'd0, irq_vector},   32'd0);
        #1;
        rst_n = 1'b1;

        // Same-cycle set and ack-clear of vector 4: set wins, no coalesce
        wr(C_ADDR, 32'd4);
        tick();
        chk("s_v4_vector", {27'd0, irq_vector}, 32'd4);
        irq_ack  = 1'b1;
        wr(C_ADDR, 32'd4);
        irq_ack  = 1'b0;
        chk("s_pend_kept", pending,               32'h10);
        chk("s_cnt_flat",  {16'd0, coalesce_cnt}, 32'd0);
        chk("s_gap",       {31'd0, irq_valid},    32'd0);
        tick();
        chk("s_represent", {31'd0, irq_valid},    32'd1);
        ack();
        chk("s_final",     pending,               32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
